// File: rtl/iterative_alu.sv
// Multi-cycle x86-style execution unit: single-cycle add/logic/shift with EFLAGS,
// plus iterative shift-add multiply and restoring unsigned divide behind valid/ready.
module iterative_alu #(
    parameter int REG_W             = 64,
    parameter int DIV_ITERS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [1:0]       req_bmd,
    input  logic [REG_W-1:0] req_s,
    input  logic [REG_W-1:0] req_t,
    input  logic [REG_W-1:0] req_eflags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [REG_W-1:0] resp_d,
    output logic [REG_W-1:0] resp_eflags,
    output logic             resp_eflags_update,
    output logic             resp_wb,
    output logic             resp_div0
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_MUL = 4'd10, OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12, OP_CMP = 4'd13, OP_TEST = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    function automatic logic [REG_W-1:0] f_mask(input logic [1:0] bmd);
        return {REG_W{1'b1}} >> (REG_W - (8 << bmd));
    endfunction

    function automatic logic [REG_W-1:0] f_flags(input logic [REG_W-1:0] ef, input logic [REG_W-1:0] d,
                                                 input logic [5:0] msb, input logic cf, input logic af,
                                                 input logic of);
        logic [REG_W-1:0] r;
        r     = ef;
        r[0]  = cf;
        r[2]  = ~^d[7:0];
        r[4]  = af;
        r[6]  = (d == '0);
        r[7]  = d[msb];
        r[11] = of;
        return r;
    endfunction

    state_t                  r_state;
    logic                    r_ready, r_valid, r_upd, r_wb, r_div0;
    logic [REG_W-1:0]        r_d, r_ef_o;
    logic [3:0]              r_op;
    logic [6:0]              r_cnt, r_last;
    logic [REG_W-1:0]        r_mask, r_b, r_q, r_ef;
    logic [REG_W:0]          r_acc;

    logic [6:0]              w_n;
    logic [5:0]              w_msb, w_sh;
    logic [REG_W-1:0]        w_mask, w_s, w_t, w_b, w_d, w_ef, w_res;
    logic [REG_W:0]          w_sum;
    logic                    w_sub, w_cin, w_cf, w_af, w_of, w_iter, w_upd, w_wb, w_div0;
    logic signed [REG_W-1:0] w_sext, w_sra;
    logic [REG_W:0]          w_acc_nx;
    logic [REG_W-1:0]        w_b_nx, w_q_nx;

    assign w_n    = 7'd8 << req_bmd;
    assign w_msb  = 6'(w_n - 7'd1);
    assign w_mask = f_mask(req_bmd);
    assign w_s    = req_s & w_mask;
    assign w_t    = req_t & w_mask;
    assign w_sh   = (req_bmd == 2'd3) ? req_t[5:0] : {1'b0, req_t[4:0]};

    // Subtraction is s + ~t + !borrow_in; CF and AF are inverted carries in that case.
    assign w_sub  = (req_op == OP_SUB) || (req_op == OP_SBB) || (req_op == OP_CMP);
    assign w_cin  = (req_op == OP_SUB) || (req_op == OP_CMP) ||
                    ((req_op == OP_ADC) && req_eflags[0]) || ((req_op == OP_SBB) && !req_eflags[0]);
    assign w_b    = w_sub ? (~req_t & w_mask) : w_t;
    assign w_sum  = {1'b0, w_s} + {1'b0, w_b} + {{REG_W{1'b0}}, w_cin};
    assign w_cf   = w_sum[w_n] ^ w_sub;
    assign w_af   = (w_s[4] ^ w_b[4] ^ w_sum[4]) ^ w_sub;
    assign w_of   = (w_s[w_msb] == w_b[w_msb]) && (w_sum[w_msb] != w_s[w_msb]);
    assign w_sext = w_s | (w_s[w_msb] ? ~w_mask : '0);
    assign w_sra  = w_sext >>> w_sh;
    assign w_iter = (req_op == OP_MUL) || (((req_op == OP_DIVU) || (req_op == OP_REMU)) && (w_t != '0));

    always_comb begin
        w_d    = '0;
        w_ef   = req_eflags;
        w_upd  = 1'b0;
        w_wb   = 1'b1;
        w_div0 = 1'b0;
        case (req_op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_CMP: begin
                w_d   = w_sum[REG_W-1:0] & w_mask;
                w_ef  = f_flags(req_eflags, w_d, w_msb, w_cf, w_af, w_of);
                w_upd = 1'b1;
                w_wb  = (req_op != OP_CMP);
            end
            OP_AND, OP_OR, OP_XOR, OP_TEST: begin
                w_d   = (req_op == OP_OR) ? (w_s | w_t) : (req_op == OP_XOR) ? (w_s ^ w_t) : (w_s & w_t);
                w_ef  = f_flags(req_eflags, w_d, w_msb, 1'b0, 1'b0, 1'b0);
                w_upd = 1'b1;
                w_wb  = (req_op != OP_TEST);
            end
            OP_SLL:  w_d = (w_s << w_sh) & w_mask;
            OP_SRL:  w_d = w_s >> w_sh;
            OP_SRA:  w_d = w_sra & w_mask;
            // Only reached with a zero divisor; non-zero divisors iterate.
            OP_DIVU: begin w_d = w_mask; w_div0 = 1'b1; end
            OP_REMU: begin w_d = w_s;    w_div0 = 1'b1; end
            OP_MUL:  w_d = '0;
            default: w_wb = 1'b0;
        endcase
    end

    // MUL: acc += mcand when multiplier LSB set. DIV: shift dividend MSB into remainder, subtract if fits.
    always_comb begin
        w_acc_nx = r_acc;
        w_b_nx   = r_b;
        w_q_nx   = r_q;
        for (int i = 0; i < DIV_ITERS_PER_CYC; i++) begin
            if (r_op == OP_MUL) begin
                if (w_q_nx[0]) w_acc_nx = w_acc_nx + {1'b0, w_b_nx};
                w_b_nx = w_b_nx << 1;
                w_q_nx = w_q_nx >> 1;
            end else begin
                w_acc_nx = {w_acc_nx[REG_W-1:0], w_q_nx[REG_W-1]};
                w_q_nx   = w_q_nx << 1;
                if (w_acc_nx >= {1'b0, w_b_nx}) begin
                    w_acc_nx  = w_acc_nx - {1'b0, w_b_nx};
                    w_q_nx[0] = 1'b1;
                end
            end
        end
        w_res = (r_op == OP_MUL)  ? (w_acc_nx[REG_W-1:0] & r_mask) :
                (r_op == OP_DIVU) ? (w_q_nx & r_mask) : w_acc_nx[REG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && req_valid) begin
            r_op   <= req_op;
            r_mask <= w_mask;
            r_ef   <= req_eflags;
            r_cnt  <= '0;
            r_last <= 7'(w_n / DIV_ITERS_PER_CYC) - 7'd1;
            r_acc  <= '0;
            r_b    <= (req_op == OP_MUL) ? w_s : w_t;
            // Dividend is left-aligned so bit REG_W-1 is always the next bit to bring down.
            r_q    <= (req_op == OP_MUL) ? w_t : (w_s << (REG_W - w_n));
        end else if (r_state == S_ITER) begin
            r_acc  <= w_acc_nx;
            r_b    <= w_b_nx;
            r_q    <= w_q_nx;
            r_cnt  <= r_cnt + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_d     <= '0;
            r_ef_o  <= '0;
            r_upd   <= 1'b0;
            r_wb    <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_ready <= 1'b0;
                    if (w_iter) begin
                        r_state <= S_ITER;
                    end else begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_d     <= w_d;
                        r_ef_o  <= w_ef;
                        r_upd   <= w_upd;
                        r_wb    <= w_wb;
                        r_div0  <= w_div0;
                    end
                end
                S_ITER: if (r_cnt == r_last) begin
                    r_state <= S_DONE;
                    r_valid <= 1'b1;
                    r_d     <= w_res;
                    r_ef_o  <= r_ef;
                    r_upd   <= 1'b0;
                    r_wb    <= 1'b1;
                    r_div0  <= 1'b0;
                end
                S_DONE: if (resp_ready) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready          = r_ready;
    assign resp_valid         = r_valid;
    assign resp_d             = r_d;
    assign resp_eflags        = r_ef_o;
    assign resp_eflags_update = r_upd;
    assign resp_wb            = r_wb;
    assign resp_div0          = r_div0;
endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Multi-cycle, width-parametrised execution unit for the x86-64 core's micro-instruction backend.
- Adds MUL/DIV/REM, logical/arithmetic right shifts and x86-accurate flag rules for logical ops to the single-cycle add/logic/shift datapath.
- Uses a valid/ready request and response handshake so the issue stage can stall on long-latency ops.
- Sits between register read and writeback; one operation in flight.

Parameters:
- REG_W, 64, datapath width; must be 64 (bmd selects 8/16/32/64-bit operation inside it).
- DIV_ITERS_PER_CYC, 1, quotient/product bits resolved per iteration cycle; legal values 1, 2, 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_op  in  4  0 ADD, 1 SUB, 2 ADC, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 DIVU, 12 REMU, 13 CMP, 14 TEST; 15 reserved
- req_bmd  in  2  0=8, 1=16, 2=32, 3=64-bit operation
- req_s, req_t  in  REG_W  source operands
- req_eflags  in  REG_W  current EFLAGS (CF source; passthrough for unchanged bits)
- resp_valid  out  1  result held
- resp_ready  in  1  consumer takes result
- resp_d  out  REG_W  result, zero-extended from the active width
- resp_eflags  out  REG_W  updated EFLAGS
- resp_eflags_update  out  1  writeback must commit resp_eflags
- resp_wb  out  1  writeback must commit resp_d (0 for CMP/TEST)
- resp_div0  out  1  DIVU/REMU with a zero divisor

Behaviour:
- Reset: state IDLE; req_ready=1; all resp_* outputs 0. Reset mid-operation aborts; the partial result is discarded.
- FSM: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, MUL/DIVU/REMU) -> ITER; ITER -> DONE after N/DIV_ITERS_PER_CYC cycles, N = active width; DONE -> IDLE on resp_ready.
- Accept condition: req_valid && req_ready. req_ready=1 only in IDLE.
- Latency, accept to resp_valid: 1 cycle for single-cycle ops; N/DIV_ITERS_PER_CYC+1 cycles for MUL/DIVU/REMU (65 for 64-bit, radix-2).
- Response outputs stay stable while resp_valid && !resp_ready. Reserved op returns d=0, wb=0, eflags_update=0.
- Operand handling: operands are truncated to N bits at accept and latched; later changes on req_* are ignored.
- Shift amount: t[5:0] when N=64, t[4:0] otherwise.
- SUB/CMP/SBB: computed as s + ~t + !borrow_in. CF = borrow out (x86 sense). ADC/SBB use req_eflags[0] as carry/borrow in.
- Flag bit positions: CF 0, PF 2, AF 4, ZF 6, SF 7, OF 11.
  - PF: even parity of d[7:0].
  - ZF: d==0 over N bits.
  - SF: d[N-1].
  - AF: carry/borrow out of bit 3.
  - OF: signed overflow.
  - All other bits pass through from req_eflags.
- Flag updates per op class:
  - Arithmetic: update all six flags.
  - AND/OR/XOR/TEST: CF=OF=0, AF=0, update SF/ZF/PF.
  - Shifts, MUL, DIVU, REMU: eflags_update=0.
- Multiply: unsigned shift-add, low N bits returned.
- Divide: restoring, unsigned.
  - Divisor 0: no iteration; resp_div0=1; DIVU returns all-ones (N bits); REMU returns s. Latency 1.
- resp_div0 is 0 for every other op.

Test Plan:
- Reset, then ADD bmd=3, s=0x7FFFFFFFFFFFFFFF, t=1 -> after 1 cycle: d=0x8000000000000000, OF=1, SF=1, CF=0, ZF=0, eflags_update=1.
- SUB bmd=0, s=0x00, t=0x01 -> d=0xFF, CF=1, SF=1, AF=1, PF=1.
- CMP with equal operands 5,5 -> ZF=1, wb=0, eflags_update=1.
- DIVU bmd=2, s=100, t=7 -> resp_valid exactly 33 cycles after accept, d=14; REMU same operands -> d=2.
- DIVU t=0, s=0x1234 bmd=1 -> 1-cycle latency, d=0xFFFF, div0=1.
- MUL bmd=3, s=0xFFFFFFFFFFFFFFFF, t=2 -> d=0xFFFFFFFFFFFFFFFE.
  - Then hold resp_ready=0 for 5 cycles: outputs are stable and req_ready=0.
  - Then assert rst while a second MUL is in ITER: next cycle resp_valid=0, req_ready=1.
